// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM port scheduler.
package sdram_arb_pkg;

  localparam int DEF_ASIZE   = 22;
  localparam int DEF_LEN_W   = 10;
  localparam int DEF_USEDW_W = 16;

  // Scheduler sequence: decide, hand off the request, wait for the burst, settle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  // Index width for an n-entry selector; a single entry still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// N-way round-robin picker: first set mask bit at or after i_start, wrapping.
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW:0]    w_off;
  logic [IW:0]    w_sum;

  // Rotating a doubled copy puts the start index at bit 0.
  assign w_dbl = {i_mask, i_mask};
  assign w_rot = N'(w_dbl >> i_start);

  // Lowest set bit of the rotated mask is the nearest candidate after the start.
  always_comb begin
    w_off = '0;
    o_any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_any = 1'b1;
        w_off = (IW + 1)'(k);
      end
    end
  end

  // Undo the rotation: start + offset, folded back into 0..N-1.
  always_comb begin
    w_sum = {1'b0, i_start} + w_off;
    if (w_sum >= (IW + 1)'(N)) begin
      w_sum = w_sum - (IW + 1)'(N);
    end
    o_idx = w_sum[IW-1:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_onehot
      assign o_grant[gi] = o_any && (o_idx == IW'(gi));
    end
  endgenerate

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port SDRAM burst scheduler: round-robin per class, reads preferred,
// write-starvation guard, wrapping per-port address pointers.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_WR        = 2,
  parameter int NUM_RD        = 2,
  parameter int ASIZE         = DEF_ASIZE,
  parameter int LEN_W         = DEF_LEN_W,
  parameter int USEDW_W       = DEF_USEDW_W,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int STARVE_MAX    = 4
) (
  input  logic                        CTRL_CLK,
  input  logic                        RESET_N,
  input  logic [NUM_WR+NUM_RD-1:0]    port_en,
  input  logic [NUM_WR*ASIZE-1:0]     wr_base,
  input  logic [NUM_WR*ASIZE-1:0]     wr_max,
  input  logic [NUM_WR*LEN_W-1:0]     wr_len,
  input  logic [NUM_WR-1:0]           wr_load,
  input  logic [NUM_WR*USEDW_W-1:0]   wr_rusedw,
  input  logic [NUM_RD*ASIZE-1:0]     rd_base,
  input  logic [NUM_RD*ASIZE-1:0]     rd_max,
  input  logic [NUM_RD*LEN_W-1:0]     rd_len,
  input  logic [NUM_RD-1:0]           rd_load,
  input  logic [NUM_RD*USEDW_W-1:0]   rd_wusedw,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic                        req_write,
  output logic [ASIZE-1:0]            req_addr,
  output logic [LEN_W-1:0]            req_len,
  input  logic                        burst_done,
  output logic [NUM_WR-1:0]           wr_grant,
  output logic [NUM_RD-1:0]           rd_grant,
  output logic [NUM_WR-1:0]           wr_wrap,
  output logic [NUM_RD-1:0]           rd_wrap
);

  localparam int WIW = idx_w(NUM_WR);
  localparam int RIW = idx_w(NUM_RD);
  localparam int SW  = USEDW_W + 1;
  localparam int SCW = $clog2(STARVE_MAX + 1);

  arb_state_t r_state;
  arb_state_t w_state_next;

  logic [ASIZE-1:0]   w_wr_base [NUM_WR];
  logic [ASIZE-1:0]   w_wr_max  [NUM_WR];
  logic [LEN_W-1:0]   w_wr_len  [NUM_WR];
  logic [SW-1:0]      w_wr_used [NUM_WR];
  logic [ASIZE-1:0]   w_rd_base [NUM_RD];
  logic [ASIZE-1:0]   w_rd_max  [NUM_RD];
  logic [LEN_W-1:0]   w_rd_len  [NUM_RD];
  logic [SW-1:0]      w_rd_sum  [NUM_RD];

  logic [NUM_WR-1:0]  w_wr_elig;
  logic [NUM_RD-1:0]  w_rd_elig;
  logic [NUM_WR-1:0]  w_wr_pick;
  logic [NUM_RD-1:0]  w_rd_pick;
  logic [WIW-1:0]     w_wr_idx;
  logic [RIW-1:0]     w_rd_idx;
  logic               w_wr_any;
  logic               w_rd_any;
  logic [WIW-1:0]     w_wr_rr_next;
  logic [RIW-1:0]     w_rd_rr_next;

  logic               w_sel_write;
  logic               w_take;
  logic               w_done;

  logic               r_req_write;
  logic [ASIZE-1:0]   r_req_addr;
  logic [LEN_W-1:0]   r_req_len;
  logic [NUM_WR-1:0]  r_wr_grant;
  logic [NUM_RD-1:0]  r_rd_grant;
  logic [WIW-1:0]     r_wr_rr;
  logic [RIW-1:0]     r_rd_rr;
  logic [SCW-1:0]     r_starve;

  logic [ASIZE-1:0]   r_wr_ptr  [NUM_WR];
  logic               r_wr_hit  [NUM_WR];
  logic               r_wr_wrap [NUM_WR];
  logic [ASIZE:0]     w_wr_next [NUM_WR];
  logic               w_wr_over [NUM_WR];
  logic [ASIZE-1:0]   r_rd_ptr  [NUM_RD];
  logic               r_rd_hit  [NUM_RD];
  logic               r_rd_wrap [NUM_RD];
  logic [ASIZE:0]     w_rd_next [NUM_RD];
  logic               w_rd_over [NUM_RD];

  genvar gi;

  // Write ports: unpack buses, eligibility needs a full burst waiting in the FIFO.
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_elig
      assign w_wr_base[gi] = wr_base[gi*ASIZE +: ASIZE];
      assign w_wr_max[gi]  = wr_max[gi*ASIZE +: ASIZE];
      assign w_wr_len[gi]  = wr_len[gi*LEN_W +: LEN_W];
      assign w_wr_used[gi] = SW'(wr_rusedw[gi*USEDW_W +: USEDW_W]);
      assign w_wr_elig[gi] = port_en[gi] & ~wr_load[gi] & (w_wr_len[gi] != '0)
                           & (w_wr_used[gi] >= SW'(w_wr_len[gi]));
    end
  endgenerate

  // Read ports: the whole burst must fit; the extra sum bit keeps a full FIFO from aliasing.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_elig
      assign w_rd_base[gi] = rd_base[gi*ASIZE +: ASIZE];
      assign w_rd_max[gi]  = rd_max[gi*ASIZE +: ASIZE];
      assign w_rd_len[gi]  = rd_len[gi*LEN_W +: LEN_W];
      assign w_rd_sum[gi]  = SW'(rd_wusedw[gi*USEDW_W +: USEDW_W]) + SW'(w_rd_len[gi]);
      assign w_rd_elig[gi] = port_en[NUM_WR+gi] & ~rd_load[gi] & (w_rd_len[gi] != '0)
                           & (w_rd_sum[gi] <= SW'(RD_FIFO_DEPTH));
    end
  endgenerate

  rr_pick #(.N(NUM_WR), .IW(WIW)) u_wr_pick (
    .i_mask  (w_wr_elig),
    .i_start (r_wr_rr),
    .o_grant (w_wr_pick),
    .o_idx   (w_wr_idx),
    .o_any   (w_wr_any)
  );

  rr_pick #(.N(NUM_RD), .IW(RIW)) u_rd_pick (
    .i_mask  (w_rd_elig),
    .i_start (r_rd_rr),
    .o_grant (w_rd_pick),
    .o_idx   (w_rd_idx),
    .o_any   (w_rd_any)
  );

  // Reads normally win; a write that has waited STARVE_MAX read grants goes first.
  assign w_sel_write  = w_wr_any & (~w_rd_any | (r_starve == SCW'(STARVE_MAX)));
  assign w_take       = (r_state == IDLE) & (w_wr_any | w_rd_any);
  assign w_done       = (r_state == BUSY) & burst_done;
  assign w_wr_rr_next = (w_wr_idx == WIW'(NUM_WR - 1)) ? '0 : w_wr_idx + 1'b1;
  assign w_rd_rr_next = (w_rd_idx == RIW'(NUM_RD - 1)) ? '0 : w_rd_idx + 1'b1;

  // State register.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state: one burst in flight, ready only honoured in ISSUE, done only in BUSY.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_take)     w_state_next = ISSUE;
      ISSUE:   if (req_ready)  w_state_next = BUSY;
      BUSY:    if (burst_done) w_state_next = GAP;
      GAP:                     w_state_next = IDLE;
      default:                 w_state_next = IDLE;
    endcase
  end

  // Latch the winning request and grant at the decision; drop the grant on done.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_len   <= '0;
      r_wr_grant  <= '0;
      r_rd_grant  <= '0;
    end else if (w_take) begin
      r_req_write <= w_sel_write;
      if (w_sel_write) begin
        r_req_addr <= r_wr_ptr[w_wr_idx];
        r_req_len  <= w_wr_len[w_wr_idx];
        r_wr_grant <= w_wr_pick;
        r_rd_grant <= '0;
      end else begin
        r_req_addr <= r_rd_ptr[w_rd_idx];
        r_req_len  <= w_rd_len[w_rd_idx];
        r_wr_grant <= '0;
        r_rd_grant <= w_rd_pick;
      end
    end else if (w_done) begin
      r_wr_grant <= '0;
      r_rd_grant <= '0;
    end
  end

  // Round-robin start pointers and the starvation counter advance only at a decision.
  always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_rr  <= '0;
      r_rd_rr  <= '0;
      r_starve <= '0;
    end else if (w_take) begin
      if (w_sel_write) begin
        r_wr_rr  <= w_wr_rr_next;
        r_starve <= '0;
      end else begin
        r_rd_rr <= w_rd_rr_next;
        if (w_wr_any) r_starve <= r_starve + 1'b1;
      end
    end
  end

  // Write pointers: load wins, a load during the burst voids its done update.
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr_ptr
      assign w_wr_next[gi] = (ASIZE + 1)'(r_wr_ptr[gi]) + (ASIZE + 1)'(r_req_len);
      assign w_wr_over[gi] = ((ASIZE + 2)'(w_wr_next[gi]) + (ASIZE + 2)'(r_req_len))
                           > (ASIZE + 2)'(w_wr_max[gi]);
      assign wr_wrap[gi]   = r_wr_wrap[gi];

      // Per-port pointer, wrap pulse and load-during-burst flag.
      always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_wr_ptr[gi]  <= w_wr_base[gi];
          r_wr_hit[gi]  <= 1'b0;
          r_wr_wrap[gi] <= 1'b0;
        end else begin
          r_wr_wrap[gi] <= 1'b0;
          if (w_take)                            r_wr_hit[gi] <= 1'b0;
          else if (wr_load[gi] & r_wr_grant[gi]) r_wr_hit[gi] <= 1'b1;
          if (wr_load[gi]) begin
            r_wr_ptr[gi] <= w_wr_base[gi];
          end else if (w_done & r_wr_grant[gi] & ~r_wr_hit[gi]) begin
            if (w_wr_over[gi]) begin
              r_wr_ptr[gi]  <= w_wr_base[gi];
              r_wr_wrap[gi] <= 1'b1;
            end else begin
              r_wr_ptr[gi] <= w_wr_next[gi][ASIZE-1:0];
            end
          end
        end
      end
    end
  endgenerate

  // Read pointers: same rules as the write side.
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd_ptr
      assign w_rd_next[gi] = (ASIZE + 1)'(r_rd_ptr[gi]) + (ASIZE + 1)'(r_req_len);
      assign w_rd_over[gi] = ((ASIZE + 2)'(w_rd_next[gi]) + (ASIZE + 2)'(r_req_len))
                           > (ASIZE + 2)'(w_rd_max[gi]);
      assign rd_wrap[gi]   = r_rd_wrap[gi];

      // Per-port pointer, wrap pulse and load-during-burst flag.
      always_ff @(posedge CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_rd_ptr[gi]  <= w_rd_base[gi];
          r_rd_hit[gi]  <= 1'b0;
          r_rd_wrap[gi] <= 1'b0;
        end else begin
          r_rd_wrap[gi] <= 1'b0;
          if (w_take)                            r_rd_hit[gi] <= 1'b0;
          else if (rd_load[gi] & r_rd_grant[gi]) r_rd_hit[gi] <= 1'b1;
          if (rd_load[gi]) begin
            r_rd_ptr[gi] <= w_rd_base[gi];
          end else if (w_done & r_rd_grant[gi] & ~r_rd_hit[gi]) begin
            if (w_rd_over[gi]) begin
              r_rd_ptr[gi]  <= w_rd_base[gi];
              r_rd_wrap[gi] <= 1'b1;
            end else begin
              r_rd_ptr[gi] <= w_rd_next[gi][ASIZE-1:0];
            end
          end
        end
      end
    end
  endgenerate

  assign req_valid = (r_state == ISSUE);
  assign req_write = r_req_write;
  assign req_addr  = r_req_addr;
  assign req_len   = r_req_len;
  assign wr_grant  = r_wr_grant;
  assign rd_grant  = r_rd_grant;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: engine model plus burst scoreboard, eligibility table.
module tb_sdram_port_arbiter;

  localparam int NUM_WR = 2;
  localparam int NUM_RD = 2;
  localparam int ASIZE  = 22;
  localparam int LEN_W  = 10;
  localparam int USEDW_W = 16;
  localparam int DLY    = 8;
  localparam int TMO    = 600;

  logic                      CTRL_CLK = 1'b0;
  logic                      RESET_N;
  logic [NUM_WR+NUM_RD-1:0]  port_en;
  logic [NUM_WR*ASIZE-1:0]   wr_base, wr_max;
  logic [NUM_WR*LEN_W-1:0]   wr_len;
  logic [NUM_WR-1:0]         wr_load;
  logic [NUM_WR*USEDW_W-1:0] wr_rusedw;
  logic [NUM_RD*ASIZE-1:0]   rd_base, rd_max;
  logic [NUM_RD*LEN_W-1:0]   rd_len;
  logic [NUM_RD-1:0]         rd_load;
  logic [NUM_RD*USEDW_W-1:0] rd_wusedw;
  logic                      req_valid, req_ready, req_write;
  logic [ASIZE-1:0]          req_addr;
  logic [LEN_W-1:0]          req_len;
  logic                      burst_done = 1'b0;
  logic [NUM_WR-1:0]         wr_grant, wr_wrap;
  logic [NUM_RD-1:0]         rd_grant, rd_wrap;

  sdram_port_arbiter #(
    .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .ASIZE(ASIZE), .LEN_W(LEN_W),
    .USEDW_W(USEDW_W), .RD_FIFO_DEPTH(1024), .STARVE_MAX(4)
  ) dut (
    .CTRL_CLK(CTRL_CLK), .RESET_N(RESET_N), .port_en(port_en),
    .wr_base(wr_base), .wr_max(wr_max), .wr_len(wr_len), .wr_load(wr_load),
    .wr_rusedw(wr_rusedw), .rd_base(rd_base), .rd_max(rd_max), .rd_len(rd_len),
    .rd_load(rd_load), .rd_wusedw(rd_wusedw), .req_valid(req_valid),
    .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .burst_done(burst_done), .wr_grant(wr_grant),
    .rd_grant(rd_grant), .wr_wrap(wr_wrap), .rd_wrap(rd_wrap)
  );

  always #5 CTRL_CLK = ~CTRL_CLK;

  typedef struct {
    bit               wr;
    int               port;
    logic [ASIZE-1:0] addr;
    logic [LEN_W-1:0] len;
  } exp_t;

  typedef struct {
    logic [3:0]  en;
    logic [9:0]  wlen;
    logic [15:0] wused;
    logic        wload;
    logic [9:0]  rlen;
    logic [15:0] rused;
    logic [1:0]  ewr;
    logic [1:0]  erd;
  } vec_t;

  exp_t sb[$];
  vec_t tv[12];
  exp_t m_e;
  logic [3:0] m_eg;
  int errors = 0, checks = 0;
  int pops = 0, cd = 0, done_cnt = 0, wr_wrap_cnt = 0, rd_wrap_cnt = 0, wrap_at = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CTRL_CLK);
      #1;
    end
  endtask

  task automatic push(input bit wr, input int port, input int addr, input int len);
    exp_t e;
    e.wr = wr; e.port = port; e.addr = ASIZE'(addr); e.len = LEN_W'(len);
    sb.push_back(e);
  endtask

  task automatic wait_pops(input int target, input string name);
    int t = 0;
    while (pops < target && t < TMO) begin
      tick(1);
      t++;
    end
    if (pops < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout: accepted %0d required %0d", name, pops, target);
      sb.delete();
    end
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((cd != 0 || burst_done) && t < TMO) begin
      tick(1);
      t++;
    end
    tick(3);
  endtask

  task automatic clear_inputs();
    port_en = '0; wr_base = '0; wr_max = '1; wr_len = '0; wr_load = '0; wr_rusedw = '0;
    rd_base = '0; rd_max = '1; rd_len = '0; rd_load = '0; rd_wusedw = '0; req_ready = 1'b1;
  endtask

  task automatic apply_reset();
    RESET_N = 1'b0;
    cd = 0; burst_done = 1'b0; sb.delete();
    pops = 0; done_cnt = 0; wr_wrap_cnt = 0; rd_wrap_cnt = 0; wrap_at = 0;
    tick(2);
    RESET_N = 1'b1;
  endtask

  // Scoreboard: compare each accepted request with the next expected burst.
  always @(negedge CTRL_CLK) begin
    if (burst_done) done_cnt++;
    if (wr_wrap[0]) begin wr_wrap_cnt++; wrap_at = done_cnt; end
    if (rd_wrap != '0) rd_wrap_cnt++;
    if (req_valid && req_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected: burst at %0h with none expected", req_addr);
      end else begin
        m_e = sb.pop_front();
        m_eg = '0;
        if (m_e.wr) m_eg[m_e.port] = 1'b1;
        else        m_eg[NUM_WR + m_e.port] = 1'b1;
        chk($sformatf("acc%0d_grant", pops), {req_write, rd_grant, wr_grant}, {m_e.wr, m_eg});
        chk($sformatf("acc%0d_addr_len", pops), {req_addr, req_len}, {m_e.addr, m_e.len});
        pops++;
        cd = DLY;
      end
    end
  end

  // Engine model: one-cycle done pulse DLY cycles after each accept.
  initial begin
    forever begin
      @(posedge CTRL_CLK);
      #1;
      if (cd > 0) begin
        cd--;
        burst_done = (cd == 0);
      end else begin
        burst_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state.
    clear_inputs();
    RESET_N = 1'b0;
    tick(1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_grants", {wr_grant, rd_grant}, 4'b0);
    chk("rst_req_fields", {req_write, req_addr, req_len}, 33'd0);
    chk("rst_wraps", {wr_wrap, rd_wrap}, 4'b0);

    // Round-robin between two read ports.
    clear_inputs();
    rd_base = {22'h008000, 22'h001000};
    rd_len  = {10'd256, 10'd256};
    apply_reset();
    push(0, 0, 'h1000, 256); push(0, 1, 'h8000, 256);
    push(0, 0, 'h1100, 256); push(0, 1, 'h8100, 256);
    port_en = 4'b1100;
    wait_pops(4, "rr");
    port_en = '0;
    wait_quiet();

    // Starvation guard: write goes after exactly four read grants, then counter restarts.
    clear_inputs();
    rd_base[21:0] = 22'h010000; rd_len[9:0] = 10'd256;
    wr_base[21:0] = 22'h020000; wr_len[9:0] = 10'd256; wr_rusedw[15:0] = 16'd512;
    apply_reset();
    for (int k = 0; k < 4; k++) push(0, 0, 'h10000 + 256 * k, 256);
    push(1, 0, 'h20000, 256);
    for (int k = 4; k < 8; k++) push(0, 0, 'h10000 + 256 * k, 256);
    push(1, 0, 'h20100, 256);
    port_en = 4'b0101;
    wait_pops(10, "starve");
    port_en = '0;
    wait_quiet();

    // Pointer wrap at the limit.
    clear_inputs();
    wr_max[21:0] = 22'd1024; wr_len[9:0] = 10'd256; wr_rusedw[15:0] = 16'd512;
    apply_reset();
    push(1, 0, 0, 256); push(1, 0, 256, 256); push(1, 0, 512, 256);
    push(1, 0, 768, 256); push(1, 0, 0, 256);
    port_en = 4'b0001;
    wait_pops(5, "wrap");
    port_en = '0;
    wait_quiet();
    chk("wrap_count", wr_wrap_cnt, 1);
    chk("wrap_on_done", wrap_at, 4);
    chk("wrap_rd_none", rd_wrap_cnt, 0);
    chk("wrap_done_count", done_cnt, 5);

    // Load during the burst of the granted port discards the done update.
    clear_inputs();
    wr_base[21:0] = 22'h002000; wr_len[9:0] = 10'd128; wr_rusedw[15:0] = 16'd512;
    apply_reset();
    push(1, 0, 'h2000, 128); push(1, 0, 'h2000, 128); push(1, 0, 'h2080, 128);
    port_en = 4'b0001;
    wait_pops(1, "load_first");
    tick(2);
    chk("load_grant_held", {wr_grant, req_valid}, 3'b010);
    wr_load[0] = 1'b1;
    tick(1);
    wr_load[0] = 1'b0;
    wait_pops(3, "load");
    port_en = '0;
    wait_quiet();

    // Backpressure holds the request; reset mid-ISSUE restores base pointers.
    clear_inputs();
    rd_base[21:0] = 22'h000300; rd_len[9:0] = 10'd256;
    apply_reset();
    push(0, 0, 'h300, 256);
    port_en = 4'b0100;
    wait_pops(1, "bp_first");
    req_ready = 1'b0;
    t = 0;
    while (!req_valid && t < TMO) begin tick(1); t++; end
    chk("bp_valid_seen", req_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {req_valid, req_write, req_addr, req_len, rd_grant, wr_grant},
          {1'b1, 1'b0, 22'h000400, 10'd256, 2'b01, 2'b00});
      tick(1);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_valid", req_valid, 1'b0);
    chk("rst_mid_grants", {wr_grant, rd_grant}, 4'b0);
    push(0, 0, 'h300, 256);
    tick(1);
    req_ready = 1'b1;
    RESET_N = 1'b1;
    wait_pops(2, "bp_after_reset");
    port_en = '0;
    wait_quiet();

    // Eligibility table, port 0 of each class, request held in ISSUE.
    tv[0]  = '{4'b0000, 10'd256,  16'd512,    1'b0, 10'd256, 16'd0,      2'b00, 2'b00};
    tv[1]  = '{4'b0001, 10'd0,    16'd512,    1'b0, 10'd0,   16'd0,      2'b00, 2'b00};
    tv[2]  = '{4'b0001, 10'd256,  16'd255,    1'b0, 10'd0,   16'd0,      2'b00, 2'b00};
    tv[3]  = '{4'b0001, 10'd256,  16'd256,    1'b0, 10'd0,   16'd0,      2'b01, 2'b00};
    tv[4]  = '{4'b0001, 10'd256,  16'd512,    1'b1, 10'd0,   16'd0,      2'b00, 2'b00};
    tv[5]  = '{4'b0100, 10'd0,    16'd0,      1'b0, 10'd0,   16'd0,      2'b00, 2'b00};
    tv[6]  = '{4'b0100, 10'd0,    16'd0,      1'b0, 10'd256, 16'd768,    2'b00, 2'b01};
    tv[7]  = '{4'b0100, 10'd0,    16'd0,      1'b0, 10'd256, 16'd769,    2'b00, 2'b00};
    tv[8]  = '{4'b0101, 10'd256,  16'd512,    1'b0, 10'd256, 16'd0,      2'b00, 2'b01};
    tv[9]  = '{4'b1011, 10'd256,  16'd512,    1'b0, 10'd256, 16'd0,      2'b01, 2'b00};
    tv[10] = '{4'b0100, 10'd0,    16'd0,      1'b0, 10'd1,   16'hFFFF,   2'b00, 2'b00};
    tv[11] = '{4'b0101, 10'd1023, 16'd1023,   1'b0, 10'd256, 16'd769,    2'b01, 2'b00};
    for (int i = 0; i < 12; i++) begin
      clear_inputs();
      req_ready = 1'b0;
      port_en = tv[i].en;
      wr_len[9:0] = tv[i].wlen; wr_rusedw[15:0] = tv[i].wused; wr_load[0] = tv[i].wload;
      rd_len[9:0] = tv[i].rlen; rd_wusedw[15:0] = tv[i].rused;
      apply_reset();
      tick(3);
      chk($sformatf("elig_%0d", i), {req_valid, wr_grant, rd_grant},
          {|{tv[i].ewr, tv[i].erd}, tv[i].ewr, tv[i].erd});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Parametrised multi-port scheduler for the SDRAM controller. It arbitrates NUM_WR write FIFOs and NUM_RD read FIFOs, and keeps a wrapping address pointer for each port.
- It issues one burst request at a time to the SDRAM burst/command engine through a valid/ready handshake. It holds a one-hot grant for the whole burst, which the top level uses to steer FIFO data.
- It supersedes the fixed-priority 2W/2R scheduler. New features: round-robin arbitration within each class, a write-starvation guard, per-port enables, and wrap pulses.

Parameters:
- NUM_WR, 2, number of write ports (1..8)
- NUM_RD, 2, number of read ports (1..8)
- ASIZE, 22, SDRAM word-address width
- LEN_W, 10, burst-length field width
- USEDW_W, 16, FIFO used-word count width
- RD_FIFO_DEPTH, 1024, read FIFO capacity in words
- STARVE_MAX, 4, consecutive read grants allowed while a write is eligible

Ports:
- CTRL_CLK  in  1  controller clock
- RESET_N  in  1  reset
- port_en  in  NUM_WR+NUM_RD  per-port enable; writes occupy the low bits
- wr_base / wr_max  in  NUM_WR*ASIZE  start and limit address per write port
- wr_len  in  NUM_WR*LEN_W  burst length per write port
- wr_load  in  NUM_WR  reload pointer to wr_base (also clears the FIFO externally)
- wr_rusedw  in  NUM_WR*USEDW_W  write-FIFO read-side used count
- rd_base / rd_max / rd_len / rd_load / rd_wusedw  same as the write group, for NUM_RD ports
- req_valid  out  1  burst request
- req_ready  in  1  engine accepts request
- req_write  out  1  1 = write burst
- req_addr  out  ASIZE  burst start address
- req_len  out  LEN_W  burst length
- burst_done  in  1  one-cycle pulse at end of burst
- wr_grant  out  NUM_WR  one-hot active write port
- rd_grant  out  NUM_RD  one-hot active read port
- wr_wrap  out  NUM_WR  one-cycle pulse when a pointer wraps to base
- rd_wrap  out  NUM_RD  one-cycle pulse when a pointer wraps to base

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pointers = base inputs, round-robin pointers = 0, starve counter = 0.
- Eligibility, write port i: port_en set, wr_load=0, wr_len≠0, wr_rusedw ≥ wr_len.
- Eligibility, read port j: enabled, rd_load=0, rd_len≠0, rd_wusedw + rd_len ≤ RD_FIFO_DEPTH. The sum is computed at USEDW_W+1 bits.
- Class choice: reads win over writes, except when starve_cnt == STARVE_MAX and a write is eligible; then writes win.
- Starve counter: increments on each read grant made while any write is eligible; clears on any write grant.
- Within a class: round-robin starting at last granted index + 1, modulo N.
- FSM IDLE: if any port is eligible, latch winner, addr and len; set grant; go to ISSUE. Total latency from eligibility to req_valid = 1 cycle.
- FSM ISSUE: req_valid=1; req_write/addr/len stay stable until req_ready. On req_valid & req_ready, go to BUSY.
- FSM BUSY: wait for burst_done. On done, update the pointer, clear grant, go to GAP.
- FSM GAP: 1 cycle so FIFO counts settle, then IDLE. At most one burst is outstanding.
- Pointer update on done: next = ptr + len, computed at ASIZE+1 bits.
  - If next + len > max: ptr ← base and pulse wrap.
  - Otherwise ptr ← next.
- Load: ptr ← base on any cycle load=1; load has priority over a same-cycle done update. If load hits the granted port mid-burst, the burst completes and the done update is discarded.
- port_en deasserted mid-burst: no effect on that burst; it only affects future eligibility.
- burst_done outside BUSY is ignored. req_ready outside ISSUE is ignored.
- Grant is held from the IDLE decision through the done cycle.

Decomposition:
- Shared package sdram_arb_pkg holds the state enum (IDLE, ISSUE, BUSY, GAP) and the ASIZE/LEN_W/USEDW_W defaults.
- One sub-module, rr_pick: parametrised N-way round-robin one-hot picker with mask and last-index inputs, instantiated once per class.

Test Plan:
- Reset: assert RESET_N=0 mid-ISSUE → req_valid=0, grants 0; after release, pointers equal base.
- Round-robin: 2R ports with rd_len=256, both usedw=0, req_ready tied 1, done 8 cycles after accept → grants alternate rd0,rd1,rd0; addresses advance by 256 each.
- Starvation: read 0 always eligible, write 0 eligible with rusedw=512 → write granted after exactly 4 consecutive read grants; counter then clears.
- Wrap: base=0, max=1024, len=256 → addresses 0,256,512,768; wrap pulse on the 4th done; 5th address is 0.
- Load mid-burst: wr_load pulse during BUSY for the granted port → burst completes; next address = base, not base+len.
- Backpressure and ineligibility: req_ready held 0 for 5 cycles → req_addr/len stable and grant held. Separately, len=0 or port_en=0 → that port is never granted.
